// File: rtl/cdb_ingress_channel.sv
// -----------------------------------------------------------------------------
// cdb_ingress_channel
//
// Receive-side (in-domain) half of a CDB clock-domain-crossing channel for one
// DSU CHI channel. Flits arrive from the upstream CHI link under L-credit flow
// control and are written into a DEPTH-entry register FIFO. The Johnson-coded
// write pointer is published to the egress half, and the egress Johnson read
// pointer is synchronized back. Link credits are only issued when FIFO space
// is guaranteed, so a data write can never land on a full FIFO.
//
// Ports:
//   clk_in              in   in-domain clock (single clock)
//   rst_in              in   asynchronous active-high reset
//   rx_flitpend         in   link flit-pending hint
//   rx_flitv            in   flit valid
//   rx_flit             in   flit payload [CDB_FLIT_WIDTH]
//   rxcrdv              out  link credit grant, one credit per high cycle
//   crd_en              in   link active; credits are granted only while high
//   cdb_fifo_data_in2e  out  storage array, entry i at [W*(i+1)-1 : W*i]
//   wptr_r_in2e         out  registered Johnson write pointer
//   rptr_r_e2in         in   egress Johnson read pointer (asynchronous)
//   cdb_in_busy         out  rx_flitpend | ~empty, clock-gating hint
//   crd_err             out  sticky protocol error, cleared only by rst_in
// -----------------------------------------------------------------------------

// Default opcode field locations, used when the including environment does not
// provide the DSU CHI flit layout.
`ifndef DSU_CHI_REQ_FLIT_OPCODE_LEFT
`define DSU_CHI_REQ_FLIT_OPCODE_LEFT 7
`endif
`ifndef DSU_CHI_REQ_FLIT_OPCODE_RIGHT
`define DSU_CHI_REQ_FLIT_OPCODE_RIGHT 4
`endif
`ifndef DSU_CHI_RSP_FLIT_OPCODE_LEFT
`define DSU_CHI_RSP_FLIT_OPCODE_LEFT 7
`endif
`ifndef DSU_CHI_RSP_FLIT_OPCODE_RIGHT
`define DSU_CHI_RSP_FLIT_OPCODE_RIGHT 4
`endif
`ifndef DSU_CHI_SNP_FLIT_OPCODE_LEFT
`define DSU_CHI_SNP_FLIT_OPCODE_LEFT 7
`endif
`ifndef DSU_CHI_SNP_FLIT_OPCODE_RIGHT
`define DSU_CHI_SNP_FLIT_OPCODE_RIGHT 4
`endif
`ifndef DSU_CHI_DAT_FLIT_OPCODE_LEFT
`define DSU_CHI_DAT_FLIT_OPCODE_LEFT 7
`endif
`ifndef DSU_CHI_DAT_FLIT_OPCODE_RIGHT
`define DSU_CHI_DAT_FLIT_OPCODE_RIGHT 4
`endif

module cdb_ingress_channel #(
  parameter int CDB_FIFO_DEPTH = 8,
  parameter int CDB_FLIT_WIDTH = 8,
  parameter int CDB_CRD_MAX    = 4,
  parameter int CHANNEL        = 0
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     rx_flitpend,
  input  logic                                     rx_flitv,
  input  logic [CDB_FLIT_WIDTH-1:0]                rx_flit,
  output logic                                     rxcrdv,
  input  logic                                     crd_en,
  output logic [CDB_FLIT_WIDTH*CDB_FIFO_DEPTH-1:0] cdb_fifo_data_in2e,
  output logic [CDB_FIFO_DEPTH-1:0]                wptr_r_in2e,
  input  logic [CDB_FIFO_DEPTH-1:0]                rptr_r_e2in,
  output logic                                     cdb_in_busy,
  output logic                                     crd_err
);

  localparam int N     = CDB_FIFO_DEPTH;
  localparam int W     = CDB_FLIT_WIDTH;
  localparam int PW    = $clog2(2 * N);   // pointer position 0..2N-1
  localparam int PW1   = PW + 1;          // headroom for modular arithmetic
  localparam int SW    = PW + 2;          // headroom for crd_out + occ
  localparam int CRD_W = $clog2(CDB_CRD_MAX + 1);

  localparam logic [PW1-1:0] TWO_N = PW1'(2 * N);

  // CHANNEL: 0 = REQ, 1 = RSP, 2 = SNP, 3 = DAT
  localparam int OPC_L = (CHANNEL == 0) ? `DSU_CHI_REQ_FLIT_OPCODE_LEFT :
                         (CHANNEL == 1) ? `DSU_CHI_RSP_FLIT_OPCODE_LEFT :
                         (CHANNEL == 2) ? `DSU_CHI_SNP_FLIT_OPCODE_LEFT :
                                          `DSU_CHI_DAT_FLIT_OPCODE_LEFT;
  localparam int OPC_R = (CHANNEL == 0) ? `DSU_CHI_REQ_FLIT_OPCODE_RIGHT :
                         (CHANNEL == 1) ? `DSU_CHI_RSP_FLIT_OPCODE_RIGHT :
                         (CHANNEL == 2) ? `DSU_CHI_SNP_FLIT_OPCODE_RIGHT :
                                          `DSU_CHI_DAT_FLIT_OPCODE_RIGHT;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N-1:0]          wptr_r;
  logic [N-1:0]          wptr_oh_r;
  logic [N-1:0]          rptr_meta;
  logic [N-1:0]          sync_rptr;
  logic [N-1:0][W-1:0]   fifo_mem;
  logic [CRD_W-1:0]      crd_out;

  // ---------------------------------------------------------------------------
  // Combinational
  // ---------------------------------------------------------------------------
  logic [PW1-1:0]        wpos;
  logic [PW1-1:0]        rpos;
  logic [PW1-1:0]        occ;
  logic                  empty;
  logic                  full;
  logic                  grant;
  logic                  flit_err;
  logic                  do_write;
  logic                  consume;
  logic [CRD_W-1:0]      crd_out_next;

  // Johnson position: the number of ones while the MSB is clear, otherwise
  // the pointer is in its second half and counts back from 2N.
  function automatic logic [PW1-1:0] ptr_pos(input logic [N-1:0] p);
    logic [PW1-1:0] ones;
    ones = '0;
    for (int i = 0; i < N; i++) ones = ones + PW1'(p[i]);
    return p[N-1] ? (TWO_N - ones) : ones;
  endfunction

  // ---------------------------------------------------------------------------
  // Egress read pointer synchronizer (2 flops). The Johnson code changes one
  // bit per step, so a sampled value is always either the old or new pointer.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rptr_meta <= '0;
      sync_rptr <= '0;
    end else begin
      rptr_meta <= rptr_r_e2in;
      sync_rptr <= rptr_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy and status. sync_rptr lags the egress, so occ can only
  // overestimate, which keeps the credit decision safe.
  // ---------------------------------------------------------------------------
  assign wpos  = ptr_pos(wptr_r);
  assign rpos  = ptr_pos(sync_rptr);
  assign occ   = (wpos >= rpos) ? (wpos - rpos) : (wpos + TWO_N - rpos);
  assign empty = (wptr_r == sync_rptr);
  assign full  = (wptr_r == ~sync_rptr);

  // ---------------------------------------------------------------------------
  // Flit classification
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the if-chain leaves it unassigned and infers a latch.
  always_comb begin
    flit_err = 1'b0;
    do_write = 1'b0;
    consume  = 1'b0;
    if (rx_flitv) begin
      if (crd_out == '0) begin
        flit_err = 1'b1;                       // flit without a credit
      end else if (rx_flit[OPC_L:OPC_R] == '0) begin
        consume  = 1'b1;                       // LCrdReturn, no write
      end else if (full) begin
        flit_err = 1'b1;                       // defensive: never overwrite
      end else begin
        do_write = 1'b1;
        consume  = 1'b1;
      end
    end
  end

  // A credit is granted only if the FIFO can absorb every credit already out
  // plus this one, counting entries the egress may not yet have released.
  assign grant = crd_en
              && (crd_out < CRD_W'(CDB_CRD_MAX))
              && ((SW'(crd_out) + SW'(occ)) < SW'(N));

  assign crd_out_next = crd_out + CRD_W'(grant) - CRD_W'(consume);

  // ---------------------------------------------------------------------------
  // Credit state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      crd_out <= '0;
      rxcrdv  <= 1'b0;
      crd_err <= 1'b0;
    end else begin
      crd_out <= crd_out_next;
      rxcrdv  <= grant;
      if (flit_err) crd_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointers. The one-hot pointer selects the slot; the Johnson pointer
  // is what crosses to the egress domain.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wptr_r    <= '0;
      wptr_oh_r <= N'(1);
    end else if (do_write) begin
      wptr_r    <= {wptr_r[N-2:0], ~wptr_r[N-1]};
      wptr_oh_r <= {wptr_oh_r[N-2:0], wptr_oh_r[N-1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Data and wptr_r update on the same edge; the egress two-flop
  // pointer sync makes the data stable long before the pointer is seen.
  // ---------------------------------------------------------------------------
  // NOTE: the storage is reset because the egress reads it directly through
  // the flat output; a defined reset value keeps that bus free of X.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fifo_mem <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (do_write && wptr_oh_r[i]) fifo_mem[i] <= rx_flit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cdb_fifo_data_in2e = fifo_mem;
  assign wptr_r_in2e        = wptr_r;
  assign cdb_in_busy        = rx_flitpend | ~empty;

endmodule

// File: tb/tb_cdb_ingress_channel.sv
// -----------------------------------------------------------------------------
// tb_cdb_ingress_channel
//
// Directed bench for cdb_ingress_channel with default parameters (DEPTH 8,
// 8-bit flits, 4 credits, opcode in bits [7:4]). The link side holds a credit
// count built from observed rxcrdv pulses; the egress side is modelled by a
// Johnson read pointer driven from a read counter.
// -----------------------------------------------------------------------------
module tb_cdb_ingress_channel;

  localparam int N       = 8;
  localparam int W       = 8;
  localparam int CRD_MAX = 4;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rx_flitpend;
  logic             rx_flitv;
  logic [W-1:0]     rx_flit;
  logic             rxcrdv;
  logic             crd_en;
  logic [W*N-1:0]   fifo_data;
  logic [N-1:0]     wptr;
  logic [N-1:0]     rptr;
  logic             busy;
  logic             crd_err;

  int vectors     = 0;
  int miscompares = 0;
  int credits     = 0;   // credits currently held by the link model
  int grants      = 0;   // total rxcrdv pulses seen
  int wr_cnt      = 0;   // data writes issued
  int rd_cnt      = 0;   // entries consumed by the egress model

  logic [W-1:0] mem_model [N];
  logic [W-1:0] exp_q [$];

  cdb_ingress_channel #(
    .CDB_FIFO_DEPTH (N),
    .CDB_FLIT_WIDTH (W),
    .CDB_CRD_MAX    (CRD_MAX),
    .CHANNEL        (0)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rx_flitpend        (rx_flitpend),
    .rx_flitv           (rx_flitv),
    .rx_flit            (rx_flit),
    .rxcrdv             (rxcrdv),
    .crd_en             (crd_en),
    .cdb_fifo_data_in2e (fifo_data),
    .wptr_r_in2e        (wptr),
    .rptr_r_e2in        (rptr),
    .cdb_in_busy        (busy),
    .crd_err            (crd_err)
  );

  always #5 clk_in = ~clk_in;

  // Johnson code after k steps: k ones from the bottom for k <= N, then
  // zeros shift in from the bottom.
  function automatic logic [N-1:0] jc(input int k);
    int m;
    logic [N-1:0] v;
    m = k % (2 * N);
    for (int i = 0; i < N; i++) v[i] = (m <= N) ? (i < m) : (i >= m - N);
    return v;
  endfunction

  function automatic logic [W*N-1:0] mem_flat();
    logic [W*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = mem_model[i];
    return v;
  endfunction

  // Advance to the next sampling point and collect any credit granted.
  task automatic step();
    @(negedge clk_in);
    if (rxcrdv === 1'b1) begin
      credits++;
      grants++;
    end
  endtask

  // Present one flit for the next rising edge and update the models.
  task automatic send(input logic [W-1:0] d);
    rx_flitv = 1'b1;
    rx_flit  = d;
    credits--;
    if (d[7:4] != 4'h0) begin
      mem_model[wr_cnt % N] = d;
      exp_q.push_back(d);
      wr_cnt++;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) mem_model[i] = '0;
    exp_q.delete();
    wr_cnt  = 0;
    rd_cnt  = 0;
    credits = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_in      = 1'b1;
    crd_en      = 1'b0;
    rx_flitpend = 1'b0;
    rx_flitv    = 1'b0;
    rx_flit     = '0;
    rptr        = '0;
    clear_model();
    repeat (3) @(negedge clk_in);
    vectors++; if (rxcrdv !== 1'b0) begin miscompares++; $display("FAIL reset_rxcrdv: got %b want 0", rxcrdv); end
    vectors++; if (crd_err !== 1'b0) begin miscompares++; $display("FAIL reset_crd_err: got %b want 0", crd_err); end
    vectors++; if (wptr !== '0) begin miscompares++; $display("FAIL reset_wptr: got %h want 00", wptr); end
    vectors++; if (fifo_data !== '0) begin miscompares++; $display("FAIL reset_storage: got %h want 0", fifo_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy_idle: got %b want 0", busy); end
    rx_flitpend = 1'b1;
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy_pend: got %b want 1", busy); end
    rx_flitpend = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_credit_enable();
    crd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (rxcrdv !== (i < CRD_MAX)) begin
        miscompares++;
        $display("FAIL credit_burst[%0d]: got %b want %b", i, rxcrdv, (i < CRD_MAX));
      end
    end
    vectors++; if (credits !== CRD_MAX) begin miscompares++; $display("FAIL credit_outstanding: got %0d want %0d", credits, CRD_MAX); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fill();
    int sent = 0;
    int cyc  = 0;
    while (sent < N && cyc < 200) begin
      if (credits > 0) begin
        send(W'(8'h10 + sent));
        sent++;
      end else begin
        rx_flitv = 1'b0;
      end
      step();
      cyc++;
    end
    rx_flitv = 1'b0;
    repeat (10) step();
    vectors++; if (sent !== N) begin miscompares++; $display("FAIL fill_sent: got %0d want %0d", sent, N); end
    vectors++; if (grants !== N) begin miscompares++; $display("FAIL fill_total_credits: got %0d want %0d", grants, N); end
    vectors++; if (wptr !== 8'hFF) begin miscompares++; $display("FAIL fill_wptr: got %h want ff", wptr); end
    vectors++; if (fifo_data !== 64'h1716151413121110) begin miscompares++; $display("FAIL fill_storage: got %h want 1716151413121110", fifo_data); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fill_busy: got %b want 1", busy); end
    vectors++; if (crd_err !== 1'b0) begin miscompares++; $display("FAIL fill_crd_err: got %b want 0", crd_err); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_drain_wrap();
    logic [W-1:0] exp;
    int slot;
    int sent = 0;
    int cyc  = 0;
    bit saw_zero = 1'b0;

    // Single read: the credit appears on the third edge after rptr moves.
    exp = exp_q.pop_front();
    vectors++; if (fifo_data[0 +: W] !== exp) begin miscompares++; $display("FAIL drain_first_read: got %h want %h", fifo_data[0 +: W], exp); end
    rd_cnt = 1;
    rptr   = jc(rd_cnt);
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (rxcrdv !== (i == 2)) begin
        miscompares++;
        $display("FAIL release_credit[%0d]: got %b want %b", i, rxcrdv, (i == 2));
      end
    end

    // Stream 20 flits while the egress reads every other cycle.
    while ((sent < 20 || rd_cnt < wr_cnt) && cyc < 600) begin
      if (cyc % 2 == 0 && rd_cnt < wr_cnt) begin
        slot = rd_cnt % N;
        exp  = exp_q.pop_front();
        vectors++;
        if (fifo_data[slot*W +: W] !== exp) begin
          miscompares++;
          $display("FAIL stream_read[%0d]: got %h want %h", rd_cnt, fifo_data[slot*W +: W], exp);
        end
        rd_cnt++;
        rptr = jc(rd_cnt);
      end
      if (sent < 20 && credits > 0) begin
        send(W'(8'h20 + sent));
        sent++;
      end else begin
        rx_flitv = 1'b0;
      end
      step();
      cyc++;
      if (wptr === '0) saw_zero = 1'b1;
    end
    rx_flitv = 1'b0;
    repeat (8) step();
    vectors++; if (sent !== 20 || rd_cnt !== 28) begin miscompares++; $display("FAIL stream_done: sent %0d read %0d want 20 28", sent, rd_cnt); end
    vectors++; if (saw_zero !== 1'b1) begin miscompares++; $display("FAIL stream_wrap_zero: got %b want 1", saw_zero); end
    vectors++; if (wptr !== jc(28)) begin miscompares++; $display("FAIL stream_wptr: got %h want %h", wptr, jc(28)); end
    vectors++; if (credits !== CRD_MAX) begin miscompares++; $display("FAIL stream_credits: got %0d want %0d", credits, CRD_MAX); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stream_busy: got %b want 0", busy); end
    vectors++; if (crd_err !== 1'b0) begin miscompares++; $display("FAIL stream_crd_err: got %b want 0", crd_err); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lcrd_return();
    int g0;
    crd_en = 1'b0;
    step();
    g0 = grants;
    for (int i = 0; i < 4; i++) begin
      send(W'(i * 5));              // opcode nibble 0: LCrdReturn
      step();
    end
    rx_flitv = 1'b0;
    repeat (2) step();
    vectors++; if (grants !== g0) begin miscompares++; $display("FAIL lcrd_no_grant: got %0d want %0d", grants, g0); end
    vectors++; if (wptr !== jc(28)) begin miscompares++; $display("FAIL lcrd_wptr: got %h want %h", wptr, jc(28)); end
    vectors++; if (fifo_data !== mem_flat()) begin miscompares++; $display("FAIL lcrd_storage: got %h want %h", fifo_data, mem_flat()); end
    vectors++; if (crd_err !== 1'b0) begin miscompares++; $display("FAIL lcrd_crd_err: got %b want 0", crd_err); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_protocol_error();
    // No credits are outstanding, so this flit is a protocol error.
    rx_flitv = 1'b1;
    rx_flit  = 8'h55;
    step();
    rx_flitv = 1'b0;
    vectors++; if (crd_err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", crd_err); end
    vectors++; if (wptr !== jc(28)) begin miscompares++; $display("FAIL err_wptr: got %h want %h", wptr, jc(28)); end
    vectors++; if (fifo_data !== mem_flat()) begin miscompares++; $display("FAIL err_storage: got %h want %h", fifo_data, mem_flat()); end
    crd_en = 1'b1;
    repeat (6) step();
    vectors++; if (crd_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", crd_err); end
    vectors++; if (credits !== CRD_MAX) begin miscompares++; $display("FAIL err_regrant: got %0d want %0d", credits, CRD_MAX); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_stream();
    int sent = 0;
    int cyc  = 0;
    while (sent < 5 && cyc < 100) begin
      if (credits > 0) begin
        send(W'(8'h40 + sent));
        sent++;
      end else begin
        rx_flitv = 1'b0;
      end
      step();
      cyc++;
    end
    rx_flitv = 1'b0;
    step();
    vectors++; if (wptr !== jc(33)) begin miscompares++; $display("FAIL mid_pre_wptr: got %h want %h", wptr, jc(33)); end

    // Assert reset between edges with a flit on the link.
    rx_flitv    = 1'b1;
    rx_flit     = 8'h77;
    rx_flitpend = 1'b1;
    #2;
    rst_in = 1'b1;
    rptr   = '0;
    #1;
    vectors++; if (rxcrdv !== 1'b0) begin miscompares++; $display("FAIL mid_rxcrdv: got %b want 0", rxcrdv); end
    vectors++; if (crd_err !== 1'b0) begin miscompares++; $display("FAIL mid_crd_err: got %b want 0", crd_err); end
    vectors++; if (wptr !== '0) begin miscompares++; $display("FAIL mid_wptr: got %h want 00", wptr); end
    vectors++; if (fifo_data !== '0) begin miscompares++; $display("FAIL mid_storage: got %h want 0", fifo_data); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_pend: got %b want 1", busy); end
    rx_flitpend = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy_idle: got %b want 0", busy); end
    repeat (2) @(negedge clk_in);
    vectors++; if (wptr !== '0 || fifo_data !== '0) begin miscompares++; $display("FAIL mid_flit_ignored: wptr %h data %h want 0", wptr, fifo_data); end

    clear_model();
    rx_flitv = 1'b0;
    rst_in   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (rxcrdv !== (i < CRD_MAX)) begin
        miscompares++;
        $display("FAIL restart_burst[%0d]: got %b want %b", i, rxcrdv, (i < CRD_MAX));
      end
    end

    // First write after reset must land in slot 0.
    send(8'h99);
    step();
    rx_flitv = 1'b0;
    vectors++; if (fifo_data !== mem_flat()) begin miscompares++; $display("FAIL restart_slot0: got %h want %h", fifo_data, mem_flat()); end
    vectors++; if (wptr !== jc(1)) begin miscompares++; $display("FAIL restart_wptr: got %h want %h", wptr, jc(1)); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_in      = 1'b1;
    crd_en      = 1'b0;
    rx_flitpend = 1'b0;
    rx_flitv    = 1'b0;
    rx_flit     = '0;
    rptr        = '0;

    test_reset();
    test_credit_enable();
    test_fill();
    test_drain_wrap();
    test_lcrd_return();
    test_protocol_error();
    test_reset_mid_stream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
